changecode_seq: RTL

Parametrised, sequential successor to the combinational code converter in execution unit 2. It converts a BITS-wide operand between sign-magnitude (SM), two's complement (U2) and ones' complement (U1), selected by a mode input. The conversion runs bit-serially over the magnitude field with a start/done handshake. It sits behind the APB register block of exe_unit_2, which writes the operand and mode, pulses start, and reads the result and error once done.

---
 rtl/changecode_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/changecode_seq.sv
// changecode_seq: bit-serial converter between sign-magnitude, two's complement and ones' complement.
// One magnitude bit per CALC cycle (BITS-1 cycles); registered result and error arrive with a one-cycle o_done.
module changecode_seq #(
   parameter int BITS = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [1:0]      i_mode,
   input  logic [BITS-1:0] i_argA,
   output logic            o_ready,
   output logic            o_done,
   output logic [BITS-1:0] o_result,
   output logic            o_error
);
   localparam int CW = (BITS > 2) ? $clog2(BITS - 1) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      mode_q, mode_d;
   logic            sign_q, sign_d;
   logic [BITS-2:0] mag_q, mag_d;
   logic [BITS-2:0] work_q, work_d;
   logic            seen_q, seen_d;
   logic [BITS-1:0] result_q, result_d;
   logic            error_q, error_d;
   logic            done_q, done_d;
   logic            ready_q, ready_d;

   logic            last;
   logic            bit_in;
   logic            bit_out;
   logic            seen_nxt;
   logic            err_now;

   assign last     = (cnt_q == CW'(BITS - 2));
   assign bit_in   = mag_q[0];
   assign seen_nxt = seen_q | bit_in;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_start) state_d = CALC;
         CALC:    if (last)    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status flags are registered from the next state so they never follow inputs combinationally.
   always_comb begin
      ready_d = (state_d == IDLE);
      done_d  = (state_d == DONE);
   end

   // Modes 00/01 negate serially: copy up to and including the first 1, invert the rest.
   always_comb begin
      if (!sign_q)        bit_out = bit_in;
      else if (mode_q[1]) bit_out = ~bit_in;
      else                bit_out = seen_q ? ~bit_in : bit_in;
   end

   always_comb begin
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      sign_d   = sign_q;
      mag_d    = mag_q;
      work_d   = work_q;
      seen_d   = seen_q;
      result_d = result_q;
      error_d  = error_q;
      err_now  = 1'b0;
      if (state_q == IDLE && i_start) begin
         sign_d = i_argA[BITS-1];
         mag_d  = i_argA[BITS-2:0];
         mode_d = i_mode;
         cnt_d  = '0;
         seen_d = 1'b0;
      end else if (state_q == CALC) begin
         mag_d            = mag_q >> 1;
         work_d           = work_q >> 1;
         work_d[BITS-2]   = bit_out;
         seen_d           = seen_nxt;
         cnt_d            = cnt_q + 1'b1;
         if (last) begin
            err_now  = sign_q & ~mode_q[1] & ~seen_nxt;
            error_d  = err_now;
            result_d = err_now ? '0 : {sign_q, work_d};
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q    <= '0;
         mode_q   <= '0;
         sign_q   <= 1'b0;
         mag_q    <= '0;
         work_q   <= '0;
         seen_q   <= 1'b0;
         result_q <= '0;
         error_q  <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         sign_q   <= sign_d;
         mag_q    <= mag_d;
         work_q   <= work_d;
         seen_q   <= seen_d;
         result_q <= result_d;
         error_q  <= error_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
      end
   end

   assign o_ready  = ready_q;
   assign o_done   = done_q;
   assign o_result = result_q;
   assign o_error  = error_q;

endmodule
